// File: rtl/tpu_out_deskew.sv
// De-skews staggered PE-array column results into packed rows.
// Counts rows per job and flags rows whose columns arrive misaligned.
module tpu_out_deskew #(
  parameter int COLS  = 8,
  parameter int ACC_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [4:0]              m_rows,
  input  logic [4:0]              n_cols,
  input  logic [COLS-1:0]         col_valid,
  input  logic [COLS*ACC_W-1:0]   col_data,
  output logic [COLS*ACC_W-1:0]   gbuff_out,
  output logic                    out_valid,
  output logic [4:0]              out_addr,
  output logic                    busy,
  output logic                    done,
  output logic                    skew_err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nx;

  logic [4:0]                  m_q;
  logic [4:0]                  cnt;
  logic [COLS-1:0]             act;
  logic [COLS-1:0]             act_nx;
  logic [COLS-1:0]             av;
  logic [COLS-1:0][ACC_W-1:0]  ad;
  logic [COLS*ACC_W-1:0]       row_d;
  logic                        gate;
  logic                        accept;
  logic                        open;
  logic                        full;
  logic                        any;
  logic                        take;
  logic                        bad;

  assign gate = (state != IDLE);

  // Column c waits COLS-1-c cycles so all lanes line up with column COLS-1.
  for (genvar c = 0; c < COLS; c++) begin : g_lane
    localparam int D = COLS - 1 - c;
    if (D == 0) begin : g_pass
      assign av[c] = gate & col_valid[c];
      assign ad[c] = col_data[c*ACC_W +: ACC_W];
    end else begin : g_dly
      logic [D-1:0]     vq;
      logic [ACC_W-1:0] dq [D];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vq <= '0;
          for (int i = 0; i < D; i++) dq[i] <= '0;
        end else begin
          vq[0] <= gate & col_valid[c];
          dq[0] <= col_data[c*ACC_W +: ACC_W];
          for (int i = 1; i < D; i++) begin
            vq[i] <= vq[i-1];
            dq[i] <= dq[i-1];
          end
        end
      end
      assign av[c] = vq[D-1];
      assign ad[c] = dq[D-1];
    end
  end

  always_comb begin
    act_nx = '0;
    row_d  = '0;
    for (int c = 0; c < COLS; c++) begin
      act_nx[c] = (c < int'(n_cols));
      row_d[c*ACC_W +: ACC_W] = act[c] ? ad[c] : '0;
    end
  end

  assign accept = (state == IDLE) && start && (m_rows != '0) && (n_cols != '0);
  assign open   = (state == RUN) && (cnt != m_q);
  assign full   = ((av & act) == act);
  assign any    = |(av & act);
  assign take   = open && full;
  assign bad    = open && any && !full;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (cnt == m_q) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      m_q       <= '0;
      act       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      gbuff_out <= '0;
      skew_err  <= 1'b0;
    end else begin
      state     <= state_nx;
      out_valid <= take;
      if (accept) begin
        m_q      <= m_rows;
        act      <= act_nx;
        cnt      <= '0;
        skew_err <= 1'b0;
      end
      if (take) begin
        gbuff_out <= row_d;
        out_addr  <= cnt;
        cnt       <= cnt + 5'd1;
      end
      if (bad) skew_err <= 1'b1;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_tpu_out_deskew.sv
// Scoreboard bench for tpu_out_deskew: driver pushes expected rows,
// negedge monitor pops and compares address, data, arrival cycle, done.
module tb_tpu_out_deskew;
  localparam int COLS  = 8;
  localparam int ACC_W = 32;
  localparam int W     = COLS * ACC_W;
  localparam int L     = 48;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [4:0]      m_rows;
  logic [4:0]      n_cols;
  logic [COLS-1:0] col_valid;
  logic [W-1:0]    col_data;
  logic [W-1:0]    gbuff_out;
  logic            out_valid;
  logic [4:0]      out_addr;
  logic            busy;
  logic            done;
  logic            skew_err;

  tpu_out_deskew #(.COLS(COLS), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .m_rows(m_rows),
    .n_cols(n_cols), .col_valid(col_valid), .col_data(col_data),
    .gbuff_out(gbuff_out), .out_valid(out_valid), .out_addr(out_addr),
    .busy(busy), .done(done), .skew_err(skew_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]   addr;
    logic [W-1:0] data;
    int           cyc;
    bit           last;
  } exp_t;

  exp_t            q[$];
  exp_t            e;
  int              checks = 0;
  int              errors = 0;
  int              cyc = 0;
  int              dones = 0;
  int              base = 0;
  bit              exp_done = 1'b0;
  logic [COLS-1:0] sv [L];
  logic [W-1:0]    sd [L];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [W-1:0] got, logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (done || exp_done) chk("done_pulse", W'(done), W'(exp_done));
      if (done) dones++;
      exp_done = 1'b0;
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word addr %0d", out_addr);
        end else begin
          e = q.pop_front();
          chk("out_addr", W'(out_addr), W'(e.addr));
          chk("gbuff_out", gbuff_out, e.data);
          chk("arrival_cycle", W'(cyc), W'(e.cyc));
          exp_done = e.last;
        end
      end
    end
  end

  function automatic logic [W-1:0] rowval(int r, logic [7:0] tag, int n);
    logic [W-1:0] v = '0;
    for (int c = 0; c < COLS; c++)
      if (c < n) v[c*ACC_W +: ACC_W] = {tag, 8'(r), 8'h00, 8'(c)};
    return v;
  endfunction

  task automatic clear_tab();
    for (int s = 0; s < L; s++) begin
      sv[s] = '0;
      sd[s] = '0;
    end
  endtask

  task automatic place_row(int t, int r, int late, logic [7:0] tag);
    int s;
    for (int c = 0; c < COLS; c++) begin
      s = t + c + ((c == late) ? 1 : 0);
      sv[s][c] = 1'b1;
      sd[s][c*ACC_W +: ACC_W] = {tag, 8'(r), 8'h00, 8'(c)};
    end
  endtask

  task automatic push(int addr, logic [W-1:0] d, int t, bit last);
    exp_t x;
    x.addr = 5'(addr);
    x.data = d;
    x.cyc  = base + t + COLS;
    x.last = last;
    q.push_back(x);
  endtask

  task automatic start_job(int m, int n);
    start  = 1'b1;
    m_rows = 5'(m);
    n_cols = 5'(n);
    @(posedge clk);
    #1;
    start  = 1'b0;
    m_rows = '0;
    n_cols = '0;
    base   = cyc;
  endtask

  task automatic play();
    for (int s = 0; s < L; s++) begin
      col_valid = sv[s];
      col_data  = sd[s];
      @(posedge clk);
      #1;
    end
    col_valid = '0;
    col_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", W'(q.size()), W'(0));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; m_rows = '0; n_cols = '0;
    col_valid = '0; col_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", W'({out_valid, out_addr, busy, done, skew_err}), W'(0));
    chk("rst_data", gbuff_out, '0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: full width, ideal skew
    clear_tab();
    for (int r = 0; r < 3; r++) place_row(r, r, -1, 8'h01);
    start_job(3, 8);
    chk("t1_busy", W'(busy), W'(1));
    for (int r = 0; r < 3; r++) push(r, rowval(r, 8'h01, 8), r, r == 2);
    play();
    chk("t1_dones", W'(dones), W'(1));
    chk("t1_skew", W'(skew_err), W'(0));
    chk("t1_idle", W'(busy), W'(0));

    // 2: five active lanes, junk on inactive lanes
    clear_tab();
    place_row(0, 0, -1, 8'h02);
    place_row(1, 1, -1, 8'h02);
    for (int s = 0; s < L; s++)
      for (int c = 5; c < COLS; c++) begin
        sv[s][c] = (s % 2) == 1;
        sd[s][c*ACC_W +: ACC_W] = 32'hDEAD;
      end
    start_job(2, 5);
    push(0, rowval(0, 8'h02, 5), 0, 1'b0);
    push(1, rowval(1, 8'h02, 5), 1, 1'b1);
    play();
    chk("t2_dones", W'(dones), W'(2));
    chk("t2_skew", W'(skew_err), W'(0));

    // 3: column 3 of row 1 one cycle late
    clear_tab();
    place_row(0, 0, -1, 8'h03);
    place_row(2, 1, 3, 8'h03);
    place_row(4, 2, -1, 8'h03);
    place_row(6, 3, -1, 8'h03);
    start_job(3, 8);
    push(0, rowval(0, 8'h03, 8), 0, 1'b0);
    push(1, rowval(2, 8'h03, 8), 4, 1'b0);
    push(2, rowval(3, 8'h03, 8), 6, 1'b1);
    play();
    chk("t3_dones", W'(dones), W'(3));
    chk("t3_skew", W'(skew_err), W'(1));

    // 4: rejected starts, accepted start, ignored start while busy
    start_job(0, 3);
    chk("t4_m0_busy", W'(busy), W'(0));
    start_job(3, 0);
    chk("t4_n0_busy", W'(busy), W'(0));
    chk("t4_skew_kept", W'(skew_err), W'(1));
    start_job(2, 8);
    chk("t4_busy", W'(busy), W'(1));
    chk("t4_skew_clr", W'(skew_err), W'(0));
    start_job(5, 8);
    clear_tab();
    place_row(0, 0, -1, 8'h04);
    place_row(1, 1, -1, 8'h04);
    push(0, rowval(0, 8'h04, 8), 0, 1'b0);
    push(1, rowval(1, 8'h04, 8), 1, 1'b1);
    play();
    chk("t4_dones", W'(dones), W'(4));
    chk("t4_idle", W'(busy), W'(0));

    // 5: reset during a job, then a fresh single-row job
    clear_tab();
    place_row(0, 0, -1, 8'h05);
    place_row(1, 1, -1, 8'h05);
    start_job(3, 8);
    push(0, rowval(0, 8'h05, 8), 0, 1'b0);
    push(1, rowval(1, 8'h05, 8), 1, 1'b0);
    play();
    chk("t5_busy_pre", W'(busy), W'(1));
    rst = 1'b1;
    #2;
    chk("t5_rst_ctrl", W'({out_valid, out_addr, busy, done, skew_err}), W'(0));
    chk("t5_rst_data", gbuff_out, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_no_done", W'(dones), W'(4));
    clear_tab();
    place_row(0, 0, -1, 8'h06);
    start_job(1, 8);
    push(0, rowval(0, 8'h06, 8), 0, 1'b1);
    play();
    chk("t5_dones", W'(dones), W'(5));

    // 6: 31 back-to-back rows
    clear_tab();
    for (int r = 0; r < 31; r++) place_row(r, r, -1, 8'h07);
    start_job(31, 8);
    for (int r = 0; r < 31; r++) push(r, rowval(r, 8'h07, 8), r, r == 30);
    play();
    chk("t6_dones", W'(dones), W'(6));
    chk("t6_skew", W'(skew_err), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
